// File: rtl/pingpong_ram_pkg.sv
// Shared types and default sizing for the ping-pong RAM.
package pingpong_ram_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } bank_state_t;
endpackage

// File: rtl/pingpong_bank.sv
// One storage bank: byte-enable synchronous write, combinational read.
module pingpong_bank
  import pingpong_ram_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int BE_W   = DATA_W / 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pingpong_ram.sv
// Two-bank ping-pong RAM: bank ownership state machine, pointers, read register, error flags.
// Optional sticky protocol-error flags are enabled by defining PINGPONG_RAM_ERR_EN.
module pingpong_ram
  import pingpong_ram_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int BE_W   = DATA_W / 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              wr_commit,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_avail,
  input  logic              rd_release,
  output logic              err_wr,
  output logic              err_rd
);

  bank_state_t       st [2];
  bank_state_t       st_n [2];
  logic              wsel, rsel, wsel_n, rsel_n;
  logic              wr_fire, commit_fire, rd_fire, rel_fire;
  logic [DATA_W-1:0] bank_rdata [2];

  assign wr_ready    = (st[wsel] == FILL);
  assign rd_avail    = (st[rsel] == FULL);
  assign wr_fire     = wr_valid & wr_ready & ~rst;
  assign commit_fire = wr_commit & wr_ready;
  assign rd_fire     = rd_en & rd_avail;
  assign rel_fire    = rd_release & rd_avail;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .we    (wr_fire && (wsel == 1'(b))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .wbe   (wr_be),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  // Commit is resolved first so release can see where the writer lands next.
  always_comb begin
    st_n   = st;
    wsel_n = wsel;
    rsel_n = rsel;
    if (commit_fire) begin
      st_n[wsel] = FULL;
      wsel_n     = ~wsel;
      if (st[~wsel] == FREE) st_n[~wsel] = FILL;
    end
    if (rel_fire) begin
      rsel_n     = ~rsel;
      st_n[rsel] = (rsel == wsel_n) ? FILL : FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]    <= FILL;
      st[1]    <= FREE;
      wsel     <= 1'b0;
      rsel     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      st       <= st_n;
      wsel     <= wsel_n;
      rsel     <= rsel_n;
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= bank_rdata[rsel];
    end
  end

`ifdef PINGPONG_RAM_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_wr <= 1'b0;
      err_rd <= 1'b0;
    end else begin
      if ((wr_valid | wr_commit) & ~wr_ready) err_wr <= 1'b1;
      if ((rd_en | rd_release) & ~rd_avail)   err_rd <= 1'b1;
    end
  end
`else
  assign err_wr = 1'b0;
  assign err_rd = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_ram.sv
// Directed vector bench for pingpong_ram (DATA_W=64, DEPTH=8).
module tb_pingpong_ram;

`ifdef PINGPONG_RAM_ERR_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wr_valid, wr_ready, wr_commit, rd_en, rd_valid, rd_avail, rd_release;
  logic        err_wr, err_rd;
  logic [2:0]  wr_addr, rd_addr;
  logic [63:0] wr_data, rd_data;
  logic [7:0]  wr_be;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pingpong_ram #(.DATA_W(64), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_commit(wr_commit),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_avail(rd_avail), .rd_release(rd_release),
    .err_wr(err_wr), .err_rd(err_rd)
  );

  typedef struct {
    logic        rst, wv;
    logic [2:0]  wa;
    logic [63:0] wd;
    logic [7:0]  wbe;
    logic        wc, re;
    logic [2:0]  ra;
    logic        rr;
    logic        x_ready, x_avail, x_valid;
    logic [63:0] x_data;
    logic        x_ew, x_er;
  } vec_t;

  function automatic vec_t mk(input logic r, wv, input logic [2:0] wa, input logic [63:0] wd,
                              input logic [7:0] wbe, input logic wc, re, input logic [2:0] ra,
                              input logic rr, input logic xr, xa, xv, input logic [63:0] xd,
                              input logic xew, xer);
    vec_t v;
    v.rst = r; v.wv = wv; v.wa = wa; v.wd = wd; v.wbe = wbe; v.wc = wc;
    v.re = re; v.ra = ra; v.rr = rr;
    v.x_ready = xr; v.x_avail = xa; v.x_valid = xv; v.x_data = xd;
    v.x_ew = xew; v.x_er = xer;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive at a falling edge, clock once, check at the next falling edge.
  task automatic apply(input vec_t v);
    rst = v.rst; wr_valid = v.wv; wr_addr = v.wa; wr_data = v.wd; wr_be = v.wbe;
    wr_commit = v.wc; rd_en = v.re; rd_addr = v.ra; rd_release = v.rr;
    @(posedge clk);
    @(negedge clk);
    chk("wr_ready", n_vec, 64'(wr_ready), 64'(v.x_ready));
    chk("rd_avail", n_vec, 64'(rd_avail), 64'(v.x_avail));
    chk("rd_valid", n_vec, 64'(rd_valid), 64'(v.x_valid));
    chk("rd_data",  n_vec, rd_data, v.x_data);
    chk("err_wr",   n_vec, 64'(err_wr), 64'(v.x_ew));
    chk("err_rd",   n_vec, 64'(err_rd), 64'(v.x_er));
    n_vec++;
  endtask

  localparam logic [63:0] BASE = 64'h1111_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] HALF = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] VA   = 64'hAAAA_5555_0000_00A0;
  localparam logic [63:0] VB   = 64'hBBBB_6666_0000_00B0;
  localparam logic [63:0] VC   = 64'hCCCC_7777_0000_00C0;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_be = 0; wr_commit = 0;
    rd_en = 0; rd_addr = 0; rd_release = 0;

    // Fill bank0, commit, read back; masked writes into bank1; commit+release+read together.
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0,64'h0,0,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,1,3'(i),BASE | 64'(i),8'hFF,0,0,0,0, 1,0,0,64'h0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0, 1,1,0,64'h0,0,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,0,0,0,0,0,1,3'(i),0, 1,1,1,BASE | 64'(i),0,0));
    tbl.push_back(mk(0,1,3,ONES,8'hFF,0,0,0,0, 1,1,0,BASE | 64'd7,0,0));
    tbl.push_back(mk(0,1,3,64'h0,8'h0F,0,0,0,0, 1,1,0,BASE | 64'd7,0,0));
    tbl.push_back(mk(0,1,3,64'h0,8'h00,0,0,0,0, 1,1,0,BASE | 64'd7,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,1,5,1, 1,1,1,BASE | 64'd5,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,3,0, 1,1,1,HALF,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,0,HALF,0,0));

    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i]);

    // Both banks committed: writer stalls, stray write is dropped, release revives bank0.
    apply(mk(1,0,0,0,0,0,0,0,0, 1,0,0,64'h0,0,0));
    apply(mk(0,1,0,VA,8'hFF,0,0,0,0, 1,0,0,64'h0,0,0));
    apply(mk(0,0,0,0,0,1,0,0,0, 1,1,0,64'h0,0,0));
    apply(mk(0,1,0,VB,8'hFF,0,0,0,0, 1,1,0,64'h0,0,0));
    apply(mk(0,0,0,0,0,1,0,0,0, 0,1,0,64'h0,0,0));
    apply(mk(0,1,0,VC,8'hFF,1,0,0,0, 0,1,0,64'h0,E,0));
    apply(mk(0,0,0,0,0,0,0,0,1, 1,1,0,64'h0,E,0));
    apply(mk(0,0,0,0,0,0,1,0,0, 1,1,1,VB,E,0));
    apply(mk(0,0,0,0,0,0,0,0,1, 1,0,0,VB,E,0));
    apply(mk(0,0,0,0,0,1,0,0,0, 1,1,0,VB,E,0));
    apply(mk(0,0,0,0,0,0,1,0,0, 1,1,1,VA,E,0));

    // Reset in the middle of a fill with a read in flight overrides every request.
    apply(mk(0,1,2,VC,8'hFF,0,1,0,0, 1,1,1,VA,E,0));
    apply(mk(1,1,2,VC,8'hFF,1,1,0,1, 1,0,0,64'h0,0,0));

    // Read and release with nothing available are ignored.
    apply(mk(0,0,0,0,0,0,1,0,1, 1,0,0,64'h0,0,E));
    apply(mk(0,0,0,0,0,0,0,0,0, 1,0,0,64'h0,0,E));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pingpong_ram.md
PINGPONG_RAM -- requirements
Module: pingpong_ram

Interface
REQ-001 Parameter DATA_W, default 64, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8, words per bank; SHALL be a power of two, at least 2.
REQ-003 Derived constants: BE_W = DATA_W/8; AW = log2(DEPTH).
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 wr_valid  in  1  write request.
REQ-007 wr_ready  out  1  writer owns a bank in FILL.
REQ-008 wr_addr  in  AW  word address in the writer's bank.
REQ-009 wr_data  in  DATA_W  write data.
REQ-010 wr_be  in  BE_W  byte enables; bit i controls wr_data[8i+7:8i].
REQ-011 wr_commit  in  1  hands the writer's bank to the reader.
REQ-012 rd_en  in  1  read request.
REQ-013 rd_addr  in  AW  word address in the reader's bank.
REQ-014 rd_data  out  DATA_W  registered read data.
REQ-015 rd_valid  out  1  rd_data holds a new word this cycle.
REQ-016 rd_avail  out  1  reader owns a bank in FULL.
REQ-017 rd_release  in  1  reader is finished with its bank.
REQ-018 err_wr  out  1  sticky writer-protocol error.
REQ-019 err_rd  out  1  sticky reader-protocol error.

Function
REQ-020 Two banks, each in state FREE, FILL or FULL; pointers wsel and rsel each select one bank.
REQ-021 Combinational outputs: wr_ready = (bank[wsel]==FILL); rd_avail = (bank[rsel]==FULL).
REQ-022 Write fires on wr_valid & wr_ready: bank[wsel][wr_addr] byte lanes with wr_be=1 SHALL update at the clock edge; the other lanes SHALL hold their value.
REQ-023 wr_be = 0 SHALL write nothing and is not an error.
REQ-024 Commit fires on wr_commit & wr_ready.
- bank[wsel] SHALL become FULL and wsel SHALL toggle.
- If the new bank[wsel] is FREE, it SHALL become FILL on the same edge; otherwise wr_ready stays 0 until release.
REQ-025 A write and a commit in the same cycle SHALL complete the write into the committing bank first.
REQ-026 Read fires on rd_en & rd_avail.
- rd_data SHALL equal bank[rsel][rd_addr] one cycle later, with rd_valid=1 for that one cycle.
- Otherwise rd_valid SHALL be 0 and rd_data SHALL hold its value.
REQ-027 Release fires on rd_release & rd_avail.
- rsel SHALL toggle.
- The released bank SHALL become FILL if it is bank[wsel]; otherwise it SHALL become FREE.
REQ-028 A read and a release in the same cycle SHALL return data from the released bank.
REQ-029 Simultaneous commit and release SHALL both take effect on one edge; the released bank becomes FILL, the committed bank becomes FULL.
REQ-030 wr_valid or wr_commit with wr_ready=0 SHALL be ignored; rd_en or rd_release with rd_avail=0 SHALL be ignored.
REQ-031 Latency: committed data is readable (rd_avail=1) on the cycle after the commit edge; read latency is 1 cycle.

Reset
REQ-032 On rst=1 at a clock edge, the following SHALL be set:
- bank0 = FILL, bank1 = FREE, wsel = rsel = 0;
- rd_data = 0, rd_valid = 0, err_wr = err_rd = 0.
REQ-033 rst SHALL override every concurrent request; bank memory contents SHALL NOT be cleared.
REQ-034 A reset mid-fill or mid-read SHALL discard all ownership and any pending data.

Configuration
REQ-035 Macro PINGPONG_RAM_ERR_EN defined:
- err_wr SHALL set on (wr_valid | wr_commit) & ~wr_ready;
- err_rd SHALL set on (rd_en | rd_release) & ~rd_avail;
- both SHALL clear only on rst.
REQ-036 Macro PINGPONG_RAM_ERR_EN undefined: err_wr and err_rd ports SHALL remain and SHALL be driven constant 0.

Structure
REQ-037 Shared package pingpong_ram_pkg SHALL hold the bank-state enumeration (FREE, FILL, FULL) and the default DATA_W and DEPTH constants.
REQ-038 One sub-module, pingpong_bank, SHALL be instantiated twice.
- Contents: DEPTH x DATA_W storage, byte-enable synchronous write, combinational read.
- The top level SHALL hold the state machine, pointers, output mux/register and error logic.

Verification (DATA_W=64, DEPTH=8)
REQ-039 Reset, then write addr 0..7 with 0x1111_0000_0000_000n and wr_be=0xFF, commit, read 0..7 -> rd_data matches each word 1 cycle after rd_en; rd_valid pulses 8 times.
REQ-040 Write 0xFFFF_FFFF_FFFF_FFFF to addr 3, then 0 with wr_be=0x0F, commit, read addr 3 -> 0xFFFF_FFFF_0000_0000.
REQ-041 Commit bank0 and bank1 with no release -> wr_ready=0; wr_valid writes ignored; err_wr=1 when PINGPONG_RAM_ERR_EN is defined, else 0; release -> wr_ready=1 next cycle on bank0.
REQ-042 Same-cycle wr_commit of bank1 and rd_release of bank0 -> next cycle wr_ready=1 on bank0, rd_avail=1 on bank1.
REQ-043 rst asserted during a fill and a pending read -> next cycle wr_ready=1, rd_avail=0, rd_valid=0, rd_data=0, err flags 0.
REQ-044 rd_en with rd_avail=0 after reset -> rd_valid stays 0, rd_data stays 0, err_rd=1 only with PINGPONG_RAM_ERR_EN defined.
